turn_ctrl: RTL and testbench

//  Upstream driver for the nine tic-tac-toe box cells. Converts debounced

---
 rtl/turn_ctrl_if.sv | 27 ++
 rtl/turn_ctrl.sv | 172 +++++++++++++++++
 tb/tb_turn_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/turn_ctrl_if.sv
// Bundle between key conditioning / box array and turn_ctrl.
// master drives buttons and box feedback; slave is turn_ctrl itself.
interface turn_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_place;
  logic        game_over;
  logic [17:0] box_vals;
  logic [3:0]  cursor;
  logic [8:0]  select;
  logic        curPlayer;
  logic [3:0]  move_count;
  logic        illegal;
  logic        timeout;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, game_over, box_vals,
    input  cursor, select, curPlayer, move_count, illegal, timeout
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, game_over, box_vals,
    output cursor, select, curPlayer, move_count, illegal, timeout
  );
endinterface

// File: rtl/turn_ctrl.sv
// Tic-tac-toe turn controller: 3x3 cursor, one-hot placement select, turn/move tracking.
// Optional turn forfeit after idle time is enabled by defining TURN_TIMEOUT_EN.
module turn_ctrl #(
  parameter logic        START_PLAYER   = 1'b0,
  parameter int          WRAP           = 1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000
) (
  input  logic       clk,
  input  logic       reset,
  turn_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMMIT, DONE} state_t;

  state_t     r_state, w_stateNext;
  logic [3:0] r_cursor, w_cursorNext;
  logic [8:0] r_select, w_selectNext;
  logic       r_curPlayer, w_playerNext;
  logic [3:0] r_moveCount, w_moveNext;
  logic       r_illegal, w_illegalNext;
  logic       r_upQ, r_downQ, r_leftQ, r_rightQ, r_placeQ;
  logic       w_upEdge, w_downEdge, w_leftEdge, w_rightEdge, w_placeEdge;
  logic       w_finished;
  logic [1:0] w_row, w_col;
  logic [1:0] w_cellVal;

`ifdef TURN_TIMEOUT_EN
  logic [31:0] r_idleCnt, w_idleCntNext;
  logic        r_timeout, w_timeoutNext;
  logic        w_dirEdge;
`endif

  function automatic logic [1:0] stepDec(input logic [1:0] v);
    if (v == 2'd0) return (WRAP != 0) ? 2'd2 : 2'd0;
    return v - 2'd1;
  endfunction

  function automatic logic [1:0] stepInc(input logic [1:0] v);
    if (v == 2'd2) return (WRAP != 0) ? 2'd0 : 2'd2;
    return v + 2'd1;
  endfunction

  function automatic logic [3:0] toIndex(input logic [1:0] row, input logic [1:0] col);
    return {2'b00, row} * 4'd3 + {2'b00, col};
  endfunction

  assign w_upEdge    = bus.btn_up    & ~r_upQ;
  assign w_downEdge  = bus.btn_down  & ~r_downQ;
  assign w_leftEdge  = bus.btn_left  & ~r_leftQ;
  assign w_rightEdge = bus.btn_right & ~r_rightQ;
  assign w_placeEdge = bus.btn_place & ~r_placeQ;
  assign w_finished  = bus.game_over || (r_moveCount == 4'd9);
  assign w_cellVal   = bus.box_vals[{r_cursor, 1'b0} +: 2];

  always_comb begin
    w_row = 2'd0;
    if (r_cursor >= 4'd6)      w_row = 2'd2;
    else if (r_cursor >= 4'd3) w_row = 2'd1;
    w_col = 2'(r_cursor - {2'b00, w_row} * 4'd3);
  end

  always_comb begin
    w_stateNext   = r_state;
    w_cursorNext  = r_cursor;
    w_selectNext  = '0;
    w_playerNext  = r_curPlayer;
    w_moveNext    = r_moveCount;
    w_illegalNext = 1'b0;
`ifdef TURN_TIMEOUT_EN
    w_timeoutNext = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_finished) begin
          w_stateNext = DONE;
        end else if (w_placeEdge) begin
          if (w_cellVal == 2'b00) begin
            w_stateNext  = COMMIT;
            w_selectNext = 9'd1 << r_cursor;
          end else begin
            w_illegalNext = 1'b1;
          end
        end else if (w_upEdge) begin
          w_cursorNext = toIndex(stepDec(w_row), w_col);
        end else if (w_downEdge) begin
          w_cursorNext = toIndex(stepInc(w_row), w_col);
        end else if (w_leftEdge) begin
          w_cursorNext = toIndex(w_row, stepDec(w_col));
        end else if (w_rightEdge) begin
          w_cursorNext = toIndex(w_row, stepInc(w_col));
        end
`ifdef TURN_TIMEOUT_EN
        else if (r_idleCnt == TIMEOUT_CYCLES - 32'd1) begin
          w_playerNext  = ~r_curPlayer;
          w_timeoutNext = 1'b1;
        end
`endif
      end
      COMMIT: begin
        w_stateNext  = IDLE;
        w_playerNext = ~r_curPlayer;
        w_moveNext   = r_moveCount + 4'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cursor    <= 4'd4;
      r_select    <= '0;
      r_curPlayer <= START_PLAYER;
      r_moveCount <= '0;
      r_illegal   <= 1'b0;
      r_upQ       <= 1'b0;
      r_downQ     <= 1'b0;
      r_leftQ     <= 1'b0;
      r_rightQ    <= 1'b0;
      r_placeQ    <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cursor    <= w_cursorNext;
      r_select    <= w_selectNext;
      r_curPlayer <= w_playerNext;
      r_moveCount <= w_moveNext;
      r_illegal   <= w_illegalNext;
      r_upQ       <= bus.btn_up;
      r_downQ     <= bus.btn_down;
      r_leftQ     <= bus.btn_left;
      r_rightQ    <= bus.btn_right;
      r_placeQ    <= bus.btn_place;
    end
  end

`ifdef TURN_TIMEOUT_EN
  assign w_dirEdge = w_upEdge | w_downEdge | w_leftEdge | w_rightEdge;

  // Any activity in IDLE (placement attempt, cursor move, forfeit) restarts the idle count.
  always_comb begin
    w_idleCntNext = r_idleCnt;
    if (r_state == COMMIT) begin
      w_idleCntNext = '0;
    end else if (r_state == IDLE && !w_finished) begin
      if (w_placeEdge || w_dirEdge || w_timeoutNext) w_idleCntNext = '0;
      else                                           w_idleCntNext = r_idleCnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idleCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_idleCnt <= w_idleCntNext;
      r_timeout <= w_timeoutNext;
    end
  end

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  assign bus.cursor     = r_cursor;
  assign bus.select     = r_select;
  assign bus.curPlayer  = r_curPlayer;
  assign bus.move_count = r_moveCount;
  assign bus.illegal    = r_illegal;

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed bench for turn_ctrl: dutA wraps (long timeout), dutB saturates (timeout of 8 cycles).
// Timeout expectations follow TURN_TIMEOUT_EN.
module tb_turn_ctrl;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, PLACE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  turn_ctrl_if busA ();
  turn_ctrl_if busB ();

  turn_ctrl #(.START_PLAYER(1'b0), .WRAP(1), .TIMEOUT_CYCLES(32'd1000)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave)
  );

  turn_ctrl #(.START_PLAYER(1'b0), .WRAP(0), .TIMEOUT_CYCLES(32'd8)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave)
  );

  task automatic clearInputs();
    busA.btn_up = 0; busA.btn_down = 0; busA.btn_left = 0; busA.btn_right = 0;
    busA.btn_place = 0; busA.game_over = 0; busA.box_vals = '0;
    busB.btn_up = 0; busB.btn_down = 0; busB.btn_left = 0; busB.btn_right = 0;
    busB.btn_place = 0; busB.game_over = 0; busB.box_vals = '0;
  endtask

  task automatic setBtnA(input int b, input logic v);
    case (b)
      UP:      busA.btn_up = v;
      DOWN:    busA.btn_down = v;
      LEFT:    busA.btn_left = v;
      RIGHT:   busA.btn_right = v;
      default: busA.btn_place = v;
    endcase
  endtask

  task automatic setBtnB(input int b, input logic v);
    case (b)
      UP:      busB.btn_up = v;
      DOWN:    busB.btn_down = v;
      LEFT:    busB.btn_left = v;
      RIGHT:   busB.btn_right = v;
      default: busB.btn_place = v;
    endcase
  endtask

  task automatic pressA(input int b);
    setBtnA(b, 1'b1);
    @(posedge clk); #1;
    setBtnA(b, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic pressB(input int b);
    setBtnB(b, 1'b1);
    @(posedge clk); #1;
    setBtnB(b, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b0;
    #2;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b0;
    #7;
    compared++; if (busA.cursor !== 4'd4) begin mismatched++; $display("[TB] FAIL reset_cursor: got %0d expected 4", busA.cursor); end
    compared++; if (busA.select !== 9'h000) begin mismatched++; $display("[TB] FAIL reset_select: got %h expected 000", busA.select); end
    compared++; if (busA.curPlayer !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_player: got %b expected 0", busA.curPlayer); end
    compared++; if (busA.move_count !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_moves: got %0d expected 0", busA.move_count); end
    compared++; if (busA.illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_illegal: got %b expected 0", busA.illegal); end
    compared++; if (busA.timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_timeout: got %b expected 0", busA.timeout); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_place();
    doReset();
    setBtnA(PLACE, 1'b1);
    @(posedge clk); #1;
    setBtnA(PLACE, 1'b0);
    compared++; if (busA.select !== 9'h010) begin mismatched++; $display("[TB] FAIL place_select: got %h expected 010", busA.select); end
    @(posedge clk); #1;
    compared++; if (busA.select !== 9'h000) begin mismatched++; $display("[TB] FAIL place_select_drop: got %h expected 000", busA.select); end
    compared++; if (busA.curPlayer !== 1'b1) begin mismatched++; $display("[TB] FAIL place_player: got %b expected 1", busA.curPlayer); end
    compared++; if (busA.move_count !== 4'd1) begin mismatched++; $display("[TB] FAIL place_moves: got %0d expected 1", busA.move_count); end
    // Reset arriving in the middle of a commit must cancel the move.
    setBtnA(PLACE, 1'b1);
    @(posedge clk); #1;
    setBtnA(PLACE, 1'b0);
    compared++; if (busA.select !== 9'h010) begin mismatched++; $display("[TB] FAIL midcommit_select: got %h expected 010", busA.select); end
    reset = 1'b0;
    #1;
    compared++; if (busA.select !== 9'h000) begin mismatched++; $display("[TB] FAIL midcommit_async_drop: got %h expected 000", busA.select); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    compared++; if (busA.move_count !== 4'd0) begin mismatched++; $display("[TB] FAIL midcommit_moves: got %0d expected 0", busA.move_count); end
    compared++; if (busA.curPlayer !== 1'b0) begin mismatched++; $display("[TB] FAIL midcommit_player: got %b expected 0", busA.curPlayer); end
  endtask

  task automatic test_illegal();
    doReset();
    busA.box_vals = 18'h00100;
    setBtnA(PLACE, 1'b1);
    @(posedge clk); #1;
    setBtnA(PLACE, 1'b0);
    compared++; if (busA.illegal !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_pulse: got %b expected 1", busA.illegal); end
    compared++; if (busA.select !== 9'h000) begin mismatched++; $display("[TB] FAIL illegal_select: got %h expected 000", busA.select); end
    @(posedge clk); #1;
    compared++; if (busA.illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_clear: got %b expected 0", busA.illegal); end
    compared++; if (busA.curPlayer !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_player: got %b expected 0", busA.curPlayer); end
    compared++; if (busA.move_count !== 4'd0) begin mismatched++; $display("[TB] FAIL illegal_moves: got %0d expected 0", busA.move_count); end
    busA.box_vals = '0;
  endtask

  task automatic test_wrap();
    int dirsA[6] = '{UP, UP, LEFT, LEFT, DOWN, RIGHT};
    int expA[6]  = '{1, 7, 6, 8, 2, 0};
    int dirsB[5] = '{UP, LEFT, UP, LEFT, DOWN};
    int expB[5]  = '{1, 0, 0, 0, 3};
    doReset();
    for (int i = 0; i < 6; i++) begin
      pressA(dirsA[i]);
      compared++; if (busA.cursor !== 4'(expA[i])) begin mismatched++; $display("[TB] FAIL wrap_cursor[%0d]: got %0d expected %0d", i, busA.cursor, expA[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      pressB(dirsB[i]);
      compared++; if (busB.cursor !== 4'(expB[i])) begin mismatched++; $display("[TB] FAIL sat_cursor[%0d]: got %0d expected %0d", i, busB.cursor, expB[i]); end
    end
  endtask

  task automatic test_simul();
    doReset();
    busA.btn_up = 1; busA.btn_right = 1; busA.btn_place = 1;
    @(posedge clk); #1;
    busA.btn_up = 0; busA.btn_right = 0; busA.btn_place = 0;
    compared++; if (busA.select !== 9'h010) begin mismatched++; $display("[TB] FAIL simul_select: got %h expected 010", busA.select); end
    compared++; if (busA.cursor !== 4'd4) begin mismatched++; $display("[TB] FAIL simul_cursor: got %0d expected 4", busA.cursor); end
    @(posedge clk); #1;
    compared++; if (busA.cursor !== 4'd4) begin mismatched++; $display("[TB] FAIL simul_cursor_after: got %0d expected 4", busA.cursor); end
    compared++; if (busA.move_count !== 4'd1) begin mismatched++; $display("[TB] FAIL simul_moves: got %0d expected 1", busA.move_count); end
  endtask

  task automatic test_full_board();
    int cells[9] = '{4, 5, 3, 0, 1, 2, 8, 6, 7};
    int moves[8] = '{RIGHT, RIGHT, UP, RIGHT, RIGHT, UP, RIGHT, RIGHT};
    logic player;
    doReset();
    player = 1'b0;
    for (int i = 0; i < 9; i++) begin
      compared++; if (busA.cursor !== 4'(cells[i])) begin mismatched++; $display("[TB] FAIL full_cursor[%0d]: got %0d expected %0d", i, busA.cursor, cells[i]); end
      setBtnA(PLACE, 1'b1);
      @(posedge clk); #1;
      setBtnA(PLACE, 1'b0);
      compared++; if (busA.select !== (9'd1 << cells[i])) begin mismatched++; $display("[TB] FAIL full_select[%0d]: got %h expected %h", i, busA.select, 9'd1 << cells[i]); end
      @(posedge clk); #1;
      busA.box_vals[cells[i]*2 +: 2] = player ? 2'b10 : 2'b01;
      player = ~player;
      compared++; if (busA.move_count !== 4'(i + 1)) begin mismatched++; $display("[TB] FAIL full_moves[%0d]: got %0d expected %0d", i, busA.move_count, i + 1); end
      compared++; if (busA.curPlayer !== player) begin mismatched++; $display("[TB] FAIL full_player[%0d]: got %b expected %b", i, busA.curPlayer, player); end
      if (i < 8) pressA(moves[i]);
    end
    @(posedge clk); #1;
    setBtnA(PLACE, 1'b1);
    @(posedge clk); #1;
    setBtnA(PLACE, 1'b0);
    compared++; if (busA.select !== 9'h000) begin mismatched++; $display("[TB] FAIL done_select: got %h expected 000", busA.select); end
    compared++; if (busA.illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL done_illegal: got %b expected 0", busA.illegal); end
    @(posedge clk); #1;
    compared++; if (busA.move_count !== 4'd9) begin mismatched++; $display("[TB] FAIL done_moves: got %0d expected 9", busA.move_count); end
    compared++; if (busA.curPlayer !== 1'b1) begin mismatched++; $display("[TB] FAIL done_player: got %b expected 1", busA.curPlayer); end
  endtask

  task automatic test_game_over();
    doReset();
    busA.game_over = 1'b1;
    @(posedge clk); #1;
    busA.game_over = 1'b0;
    pressA(UP);
    compared++; if (busA.cursor !== 4'd4) begin mismatched++; $display("[TB] FAIL gameover_cursor: got %0d expected 4", busA.cursor); end
    setBtnA(PLACE, 1'b1);
    @(posedge clk); #1;
    setBtnA(PLACE, 1'b0);
    compared++; if (busA.select !== 9'h000) begin mismatched++; $display("[TB] FAIL gameover_select: got %h expected 000", busA.select); end
    @(posedge clk); #1;
    compared++; if (busA.move_count !== 4'd0) begin mismatched++; $display("[TB] FAIL gameover_moves: got %0d expected 0", busA.move_count); end
  endtask

  task automatic test_timeout();
    logic expPulse;
    logic expPlayer;
`ifdef TURN_TIMEOUT_EN
    expPulse = 1'b1;
    expPlayer = 1'b1;
`else
    expPulse = 1'b0;
    expPlayer = 1'b0;
`endif
    doReset();
    repeat (7) @(posedge clk);
    #1;
    compared++; if (busB.timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_early: got %b expected 0", busB.timeout); end
    compared++; if (busB.curPlayer !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_early_player: got %b expected 0", busB.curPlayer); end
    @(posedge clk); #1;
    compared++; if (busB.timeout !== expPulse) begin mismatched++; $display("[TB] FAIL timeout_pulse: got %b expected %b", busB.timeout, expPulse); end
    compared++; if (busB.curPlayer !== expPlayer) begin mismatched++; $display("[TB] FAIL timeout_player: got %b expected %b", busB.curPlayer, expPlayer); end
    compared++; if (busB.move_count !== 4'd0) begin mismatched++; $display("[TB] FAIL timeout_moves: got %0d expected 0", busB.move_count); end
    @(posedge clk); #1;
    compared++; if (busB.timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_single: got %b expected 0", busB.timeout); end
    compared++; if (busB.curPlayer !== expPlayer) begin mismatched++; $display("[TB] FAIL timeout_player_hold: got %b expected %b", busB.curPlayer, expPlayer); end
  endtask

  initial begin
    test_reset();
    test_place();
    test_illegal();
    test_wrap();
    test_simul();
    test_full_board();
    test_game_over();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
